// File: rtl/gppm_sequencer_if.sv
// gppm_sequencer_if: bundles the program-load port, the start control, the
// datapath control outputs and the status outputs of gppm_sequencer.
//   slave  : sequencer side (takes program/start/isZero, drives datapath + status)
//   master : environment side (program loader, controller and datapath)
`timescale 1ns / 1ps
interface gppm_sequencer_if;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [49:0] prog_data;
  logic        start;
  logic        isZero;
  logic [3:0]  raddr1;
  logic [3:0]  raddr2;
  logic [3:0]  waddr;
  logic        wen;
  logic        wdsrc;
  logic [3:0]  func;
  logic [31:0] constant;
  logic        busy;
  logic        done;
  logic        error;
  logic [3:0]  pc;

  modport master (
    output prog_we, prog_addr, prog_data, start, isZero,
    input  raddr1, raddr2, waddr, wen, wdsrc, func, constant, busy, done, error, pc
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, isZero,
    output raddr1, raddr2, waddr, wen, wdsrc, func, constant, busy, done, error, pc
  );
endinterface

// File: rtl/gppm_sequencer.sv
// gppm_sequencer: program sequencer for the GPPM register-file/ALU datapath.
// Holds a 16 x 50-bit instruction memory and, once started, retires one
// instruction per clock (LOADI / ALU / BEQZ / HALT) with a step watchdog.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    gppm_sequencer_if.slave: program port, start, isZero in;
//          raddr1/raddr2/waddr/wen/wdsrc/func/constant and busy/done/error/pc out
`timescale 1ns / 1ps
module gppm_sequencer #(
  parameter int unsigned MAX_STEPS = 255
) (
  input logic               clk,
  input logic               rst_n,
  gppm_sequencer_if.slave   bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;
  localparam logic [1:0] StErr  = 2'd3;

  localparam logic [1:0] OpLoadi = 2'd0;
  localparam logic [1:0] OpAlu   = 2'd1;
  localparam logic [1:0] OpBeqz  = 2'd2;

  localparam logic [7:0] StepLast = 8'(MAX_STEPS - 1);

  logic [49:0] mem_q [16];
  logic [1:0]  state_q, state_d;
  logic [3:0]  pc_q, pc_d;
  logic [7:0]  steps_q, steps_d;

  logic [49:0] instr;
  logic [1:0]  op;
  logic [3:0]  fn, rd, rs1, rs2;
  logic [31:0] imm;

  assign instr = mem_q[pc_q];
  assign op    = instr[49:48];
  assign fn    = instr[47:44];
  assign rd    = instr[43:40];
  assign rs1   = instr[39:36];
  assign rs2   = instr[35:32];
  assign imm   = instr[31:0];

  // Program writes are dropped while running; not reset.
  always_ff @(posedge clk) begin
    if (bus.prog_we && (state_q != StRun)) begin
      mem_q[bus.prog_addr] <= bus.prog_data;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    steps_d = steps_q;
    if (state_q == StRun) begin
      if (op == 2'd3) begin
        state_d = StDone;
      end else begin
        steps_d = steps_q + 8'd1;
        pc_d    = ((op == OpBeqz) && bus.isZero) ? imm[3:0] : pc_q + 4'd1;
        // The instruction retiring at the limit still completes, then we stop.
        if (steps_q == StepLast) begin
          state_d = StErr;
        end
      end
    end else if (bus.start) begin
      state_d = StRun;
      pc_d    = 4'd0;
      steps_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= 4'd0;
      steps_q <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      steps_q <= steps_d;
    end
  end

  always_comb begin
    bus.raddr1   = 4'd0;
    bus.raddr2   = 4'd0;
    bus.waddr    = 4'd0;
    bus.wen      = 1'b0;
    bus.wdsrc    = 1'b0;
    bus.func     = 4'd0;
    bus.constant = 32'd0;
    if (state_q == StRun) begin
      case (op)
        OpLoadi: begin
          bus.wen      = 1'b1;
          bus.waddr    = rd;
          bus.constant = imm;
        end
        OpAlu: begin
          bus.wen    = 1'b1;
          bus.wdsrc  = 1'b1;
          bus.waddr  = rd;
          bus.raddr1 = rs1;
          bus.raddr2 = rs2;
          bus.func   = fn;
        end
        OpBeqz: begin
          bus.raddr1 = rs1;
          bus.raddr2 = rs2;
          bus.func   = fn;
        end
        default: ;
      endcase
    end
    // No datapath write may happen on a reset edge.
    if (!rst_n) begin
      bus.wen = 1'b0;
    end
  end

  assign bus.busy  = (state_q == StRun);
  assign bus.done  = (state_q == StDone);
  assign bus.error = (state_q == StErr);
  assign bus.pc    = pc_q;

endmodule

// File: tb/tb_gppm_sequencer.sv
`timescale 1ns / 1ps
module tb_gppm_sequencer;

  localparam int MaxSteps = 20;

  typedef struct {
    logic [3:0]  pc, r1, r2, wa, fn;
    logic        we, ws;
    logic [31:0] k;
  } step_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gppm_sequencer_if bus ();

  gppm_sequencer #(.MAX_STEPS(MaxSteps)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [49:0] pm [16];
  logic [31:0] env_rf [16];
  step_t       exp_q [$];
  logic [3:0]  obs_pc [$];
  logic        fdone, ferr;
  logic [3:0]  fpc;

  function automatic logic [31:0] alu(input logic [3:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
    case (f)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      default: return a;
    endcase
  endfunction

  // Datapath stand-in: register file plus ALU zero flag.
  assign bus.isZero = (alu(bus.func, env_rf[bus.raddr1], env_rf[bus.raddr2]) == 32'd0);

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) env_rf[i] <= 32'd0;
    end else if (bus.wen) begin
      env_rf[bus.waddr] <= bus.wdsrc ? alu(bus.func, env_rf[bus.raddr1], env_rf[bus.raddr2])
                                     : bus.constant;
    end
  end

  function automatic logic [49:0] ins(input logic [1:0] op, input logic [3:0] fn,
                                      input logic [3:0] rd, input logic [3:0] rs1,
                                      input logic [3:0] rs2, input logic [31:0] imm);
    return {op, fn, rd, rs1, rs2, imm};
  endfunction

  function automatic logic [63:0] dut_vec();
    return {7'd0, bus.busy, bus.done, bus.error, bus.pc, bus.raddr1, bus.raddr2, bus.waddr,
            bus.func, bus.wen, bus.wdsrc, bus.constant};
  endfunction

  function automatic logic [63:0] step_vec(input step_t s);
    return {7'd0, 1'b1, 1'b0, 1'b0, s.pc, s.r1, s.r2, s.wa, s.fn, s.we, s.ws, s.k};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s: observed %h required %h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = 4'(i);
      bus.prog_data = pm[i];
      tick();
    end
    bus.prog_we = 1'b0;
  endtask

  // Architectural execution of pm from pc 0 against a copy of the datapath registers.
  task automatic build_model();
    logic [31:0] rf [16];
    logic [49:0] w;
    logic [3:0]  p, np;
    int          n;
    bit          fin;
    step_t       s;
    for (int i = 0; i < 16; i++) rf[i] = env_rf[i];
    exp_q.delete();
    p = 4'd0;
    n = 0;
    fin = 1'b0;
    for (int k = 0; k < 300 && !fin; k++) begin
      w = pm[p];
      s = '{default: '0};
      s.pc = p;
      np = p + 4'd1;
      case (w[49:48])
        2'd0: begin s.we = 1'b1; s.wa = w[43:40]; s.k = w[31:0]; end
        2'd1: begin
          s.we = 1'b1; s.ws = 1'b1; s.wa = w[43:40];
          s.r1 = w[39:36]; s.r2 = w[35:32]; s.fn = w[47:44];
        end
        2'd2: begin
          s.r1 = w[39:36]; s.r2 = w[35:32]; s.fn = w[47:44];
          if (alu(s.fn, rf[s.r1], rf[s.r2]) == 32'd0) np = w[3:0];
        end
        default: ;
      endcase
      exp_q.push_back(s);
      if (w[49:48] == 2'd3) begin
        fin = 1'b1; fdone = 1'b1; ferr = 1'b0; fpc = p;
      end else begin
        if (s.we) rf[s.wa] = s.ws ? alu(s.fn, rf[s.r1], rf[s.r2]) : s.k;
        n++;
        if (n == MaxSteps) begin
          fin = 1'b1; fdone = 1'b0; ferr = 1'b1; fpc = np;
        end
        p = np;
      end
    end
  endtask

  // Start a run and compare every cycle; optionally poke start / prog_we mid-run,
  // or write word 0 in the same cycle as start.
  task automatic run(input string tag, input int start_at, input int we_at,
                     input bit we_with_start, input logic [49:0] w0);
    if (we_with_start) pm[0] = w0;
    build_model();
    obs_pc.delete();
    bus.start = 1'b1;
    if (we_with_start) begin
      bus.prog_we = 1'b1; bus.prog_addr = 4'd0; bus.prog_data = w0;
    end
    tick();
    bus.start = 1'b0;
    bus.prog_we = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk({tag, "_step"}, dut_vec(), step_vec(exp_q[i]));
      obs_pc.push_back(bus.pc);
      if (i == start_at) bus.start = 1'b1;
      if (i == we_at) begin
        bus.prog_we = 1'b1; bus.prog_addr = 4'd0; bus.prog_data = 50'($urandom);
      end
      tick();
      bus.start = 1'b0;
      bus.prog_we = 1'b0;
    end
    chk({tag, "_end"}, dut_vec(), {7'd0, 1'b0, fdone, ferr, fpc, 50'd0});
  endtask

  task automatic set_branch_prog();
    for (int i = 0; i < 16; i++) pm[i] = ins(2'd3, 0, 0, 0, 0, 0);
    pm[0] = ins(2'd0, 0, 1, 0, 0, 3);
    pm[1] = ins(2'd0, 0, 2, 0, 0, 1);
    pm[2] = ins(2'd1, 2, 1, 1, 2, 0);
    pm[3] = ins(2'd2, 0, 0, 1, 0, 5);
    pm[4] = ins(2'd2, 0, 0, 0, 0, 2);
  endtask

  initial begin
    logic [3:0] br_trace [11];
    br_trace = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd2, 4'd3, 4'd4, 4'd2, 4'd3, 4'd5};
    bus.prog_we = 1'b0; bus.prog_addr = 4'd0; bus.prog_data = 50'd0; bus.start = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    chk("reset_outputs", dut_vec(), 64'd0);
    rst_n = 1'b1;

    // Reset while running a LOADI: wen must drop immediately.
    for (int i = 0; i < 16; i++) pm[i] = ins(2'd0, 0, 4'(i), 0, 0, 32'(i + 100));
    load_prog();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    tick(); tick();
    chk("run_wen_before_rst", {63'd0, bus.wen}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_wen_comb", {63'd0, bus.wen}, 64'd0);
    tick();
    chk("rst_cycle1", dut_vec(), 64'd0);
    tick();
    chk("rst_cycle2", dut_vec(), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_released", dut_vec(), 64'd0);

    // Load / add.
    for (int i = 0; i < 16; i++) pm[i] = ins(2'd3, 0, 0, 0, 0, 0);
    pm[0] = ins(2'd0, 0, 1, 0, 0, 7);
    pm[1] = ins(2'd0, 0, 2, 0, 0, 5);
    pm[2] = ins(2'd1, 1, 3, 1, 2, 0);
    load_prog();
    run("add", -1, -1, 1'b0, 50'd0);
    chk("add_len", 64'(obs_pc.size()), 64'd4);
    chk("add_done_pc", {59'd0, bus.done, bus.pc}, {59'd0, 1'b1, 4'd3});
    chk("add_r3", 64'(env_rf[3]), 64'd12);

    // Branch loop.
    set_branch_prog();
    load_prog();
    run("branch", -1, -1, 1'b0, 50'd0);
    chk("br_len", 64'(obs_pc.size()), 64'd11);
    for (int i = 0; i < 11 && i < obs_pc.size(); i++) chk("br_trace", 64'(obs_pc[i]),
                                                           64'(br_trace[i]));

    // Watchdog on an infinite self-branch.
    for (int i = 0; i < 16; i++) pm[i] = ins(2'd3, 0, 0, 0, 0, 0);
    pm[0] = ins(2'd2, 0, 0, 0, 0, 0);
    load_prog();
    run("wdog", -1, -1, 1'b0, 50'd0);
    chk("wd_len", 64'(obs_pc.size()), 64'(MaxSteps));
    chk("wd_err", {61'd0, bus.busy, bus.done, bus.error}, 64'd1);

    // PC wrap with no HALT.
    for (int i = 0; i < 16; i++) pm[i] = ins(2'd0, 0, 4'(i), 0, 0, 32'(i * 3));
    load_prog();
    run("wrap", -1, -1, 1'b0, 50'd0);
    chk("wrap_len", 64'(obs_pc.size()), 64'd20);
    if (obs_pc.size() > 16) chk("wrap_15_to_0", {56'd0, obs_pc[15], obs_pc[16]}, 64'hF0);
    chk("wrap_err", {61'd0, bus.busy, bus.done, bus.error}, 64'd1);

    // Guards: start and prog_we during RUN ignored; prog_we with start lands.
    set_branch_prog();
    load_prog();
    run("guard_run", 3, 5, 1'b0, 50'd0);
    run("guard_rerun", -1, -1, 1'b0, 50'd0);
    chk("guard_rerun_len", 64'(obs_pc.size()), 64'd11);
    run("we_start", -1, -1, 1'b1, ins(2'd3, 0, 0, 0, 0, 0));
    chk("we_start_len", 64'(obs_pc.size()), 64'd1);
    chk("we_start_done", {59'd0, bus.done, bus.pc}, {59'd0, 1'b1, 4'd0});

    // Randomised programs.
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 16; i++) begin
        int sel;
        logic [1:0] op;
        logic [31:0] imm;
        sel = $urandom_range(0, 9);
        op = (sel < 4) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
        imm = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
        pm[i] = ins(op, 4'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom),
                    imm);
      end
      load_prog();
      run("rand", $urandom_range(0, 6), $urandom_range(0, 6), 1'b0, 50'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
